// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - shared state encoding, defaults and word width for dmem_ctrl
package dmem_ctrl_pkg;

  localparam int WORD_W      = 32;
  localparam int DEPTH_DEF   = 256;
  localparam int LATENCY_DEF = 4;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage: synchronous write, combinational read, never reset
module dmem_array
  import dmem_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - multi-cycle data memory controller with pipeline stall
// Optional misaligned-access rejection and misalign_o port: DMEM_MISALIGN_CHK_EN
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [31:0]       addr_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] data_o,
`ifdef DMEM_MISALIGN_CHK_EN
  output logic              misalign_o,
`endif
  output logic              stall_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [WORD_W-1:0] rdata;
  logic              mem_we;
  logic              req;
  logic              misaligned;
  logic              unused_addr;

  assign req         = MemRead_i | MemWrite_i;
  assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

`ifdef DMEM_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;
  assign misaligned = (addr_i[1:0] != 2'b00);
  assign misalign_o = misalign_q;
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    mem_we  = 1'b0;
    stall_o = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
    misalign_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          if (misaligned) begin
`ifdef DMEM_MISALIGN_CHK_EN
            misalign_d = 1'b1;
`endif
          end else begin
            stall_o = 1'b1;
            wr_d    = MemWrite_i;
            idx_d   = addr_i[AW+1:2];
            wdata_d = data_i;
            cnt_d   = LAT_M1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (cnt_q == '0) begin
          // Write wins when both strobes were set, so data_o is left alone.
          if (wr_q) mem_we = 1'b1;
          else      data_d = rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      data_q  <= '0;
`ifdef DMEM_MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
`ifdef DMEM_MISALIGN_CHK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign data_o = data_q;

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl (DEPTH=256, LATENCY=4)
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] data_o;
  logic        stall_o;
`ifdef DMEM_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] sb_q[$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_stall;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH(256), .LATENCY(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .MemRead_i  (mem_read),
    .MemWrite_i (mem_write),
    .addr_i     (addr),
    .data_i     (wdata),
    .data_o     (data_o),
`ifdef DMEM_MISALIGN_CHK_EN
    .misalign_o (misalign_o),
`endif
    .stall_o    (stall_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drives one instruction for a single cycle, counts stalled cycles until DONE,
  // then compares data_o against the scoreboard entry pushed at issue time.
  task automatic run_access(input string name, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] d,
                            input int exp_stall, input logic [31:0] exp_data);
    int n;
    int guard;
    logic [31:0] exp;
    sb_q.push_back(exp_data);
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wdata = d;
    #1;
    n = 0;
    guard = 0;
    while (stall_o === 1'b1 && guard < 40) begin
      n++;
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      #1;
      guard++;
    end
    if (guard >= 40) begin
      failures++;
      $display("FAIL %s_timeout actual=stuck_stall expected=done_within_40", name);
    end
    check({name, "_stall"}, 32'(n), 32'(exp_stall));
    exp = sb_q.pop_front();
    check({name, "_data"}, data_o, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] pat;
    logic [11:0] exp_pat;

    vecs.push_back('{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 5, 32'h0000_0000});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0010, 32'h0,         5, 32'hDEAD_BEEF});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0410, 32'h0,         5, 32'hDEAD_BEEF});
    vecs.push_back('{1'b1, 1'b1, 32'h0000_0020, 32'h0000_1234, 5, 32'hDEAD_BEEF});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0020, 32'h0,         5, 32'h0000_1234});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 5, 32'h0000_1234});
    vecs.push_back('{1'b1, 1'b0, 32'h8000_07FC, 32'h0,         5, 32'hCAFE_F00D});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0030, 32'h0000_0077, 5, 32'hCAFE_F00D});
`ifndef DMEM_MISALIGN_CHK_EN
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0013, 32'h0,         5, 32'hDEAD_BEEF});
`endif

    repeat (3) @(negedge clk);
    #1;
    check("reset_stall", {31'b0, stall_o}, 32'h0);
    check("reset_data", data_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                 vecs[i].wdata, vecs[i].exp_stall, vecs[i].exp_data);
    end

    // Reset during the second BUSY cycle of a write of 0x55 to 0x30.
    @(negedge clk);
    mem_write = 1'b1; addr = 32'h30; wdata = 32'h55;
    @(negedge clk);
    mem_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_busy_stall", {31'b0, stall_o}, 32'h0);
    check("rst_busy_data", data_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_access("after_rst_read30", 1'b1, 1'b0, 32'h30, 32'h0, 5, 32'h0000_0077);

    // Request held across DONE: two instructions, two accesses, restart after DONE.
    @(negedge clk);
    mem_read = 1'b1; addr = 32'h10;
    exp_pat = 12'b0111_1101_1111;
    pat = '0;
    for (int i = 0; i < 12; i++) begin
      #1;
      pat[i] = stall_o;
      @(negedge clk);
      if (i == 10) mem_read = 1'b0;
    end
    #1;
    check("held_pattern", {20'b0, pat}, {20'b0, exp_pat});
    check("held_data", data_o, 32'hDEAD_BEEF);
    @(negedge clk);
    #1;
    check("held_idle_stall", {31'b0, stall_o}, 32'h0);

`ifdef DMEM_MISALIGN_CHK_EN
    @(negedge clk);
    mem_read = 1'b1; addr = 32'h13;
    #1;
    check("mis_stall", {31'b0, stall_o}, 32'h0);
    check("mis_pre", {31'b0, misalign_o}, 32'h0);
    @(negedge clk);
    mem_read = 1'b0;
    #1;
    check("mis_pulse", {31'b0, misalign_o}, 32'h1);
    check("mis_idle_stall", {31'b0, stall_o}, 32'h0);
    @(negedge clk);
    #1;
    check("mis_clear", {31'b0, misalign_o}, 32'h0);
    check("mis_data", data_o, 32'hDEAD_BEEF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
